// File: rtl/bpd2_pkg.sv
// Shared branch-predictor constants and types: PHT geometry and counter reset values,
// stage-1 choice-counter constants, and the registered f2 prediction bundle.
package bpd2_pkg;

  localparam int LHISTW = 10;
  localparam int GHISTW = 12;
  localparam int LCNTW  = 3;
  localparam int GCNTW  = 2;

  localparam int LPHT_DEPTH = 1 << LHISTW;
  localparam int GPHT_DEPTH = 1 << GHISTW;

  localparam logic [LCNTW-1:0] LCNT_INIT = 3'b100;
  localparam logic [GCNTW-1:0] GCNT_INIT = 2'b10;

  // Stage-1 choice counter lives upstream; kept here so both stages agree on it.
  localparam int              CHOICE_CNTW = 2;
  localparam logic [CHOICE_CNTW-1:0] CHOICE_INIT = 2'b01;

  typedef struct packed {
    logic              pred;
    logic              lopred;
    logic              glpred;
    logic              valid;
    logic [GHISTW-1:0] ghist;
  } f2_t;

  function automatic logic pick_pred(input logic choice, input logic lo, input logic gl);
    return choice ? gl : lo;
  endfunction

endpackage

// File: rtl/bpd_satcnt_tbl.sv
// Table of saturating counters: asynchronous read, one synchronous inc/dec write per cycle.
// A same-cycle read of the entry being written returns the pre-update value; no backpressure.
module bpd_satcnt_tbl #(
  parameter int            DEPTH = 1024,
  parameter int            W     = 3,
  parameter logic [W-1:0]  INIT  = '0,
  localparam int           AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [AW-1:0] rd_idx,
  output logic [W-1:0]  rd_cnt,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_idx,
  input  logic          wr_inc
);

  localparam logic [W-1:0] CNT_MAX = '1;
  localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] wr_cur;
  logic [W-1:0] wr_nxt;

  assign rd_cnt = mem[rd_idx];
  assign wr_cur = mem[wr_idx];

  always_comb begin
    wr_nxt = wr_cur;
    if (wr_inc) begin
      if (wr_cur != CNT_MAX) wr_nxt = wr_cur + CNT_ONE;
    end else begin
      if (wr_cur != '0) wr_nxt = wr_cur - CNT_ONE;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= INIT;
    end else if (wr_en) begin
      mem[wr_idx] <= wr_nxt;
    end
  end

endmodule

// File: rtl/bpd2.sv
// Stage-2 tournament predictor: local/global PHT lookup registered into f2 one cycle after f1,
// all f2 state holds while load_fetch_i is low; retire-side updates and GHR recovery always proceed.
module bpd2
  import bpd2_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              load_fetch_i,
  input  logic              br_valid_f1_i,
  input  logic              bpd_pht_choice_f1_i,
  input  logic [LHISTW-1:0] bpd_bht_lochist_f1_i,
  input  logic              bpd_rt_we_i,
  input  logic              bpd_rt_brdir_i,
  input  logic [LHISTW-1:0] bpd_rt_lochist_i,
  input  logic [GHISTW-1:0] bpd_rt_ghist_i,
  input  logic              bpd_rt_lopred_i,
  input  logic              bpd_rt_glpred_i,
  input  logic              bpd_rt_mispred_i,
  output logic              bpd_pred_f2,
  output logic              bpd_lopred_f2,
  output logic              bpd_glpred_f2,
  output logic              bpd_valid_f2,
  output logic [GHISTW-1:0] bpd_ghist_f2,
  output logic              bpd_ch_we_o,
  output logic              bpd_ch_brdir_o
);

  logic [GHISTW-1:0] ghr;
  logic [LCNTW-1:0]  loc_cnt;
  logic [GCNTW-1:0]  glb_cnt;
  logic              lo_dir;
  logic              gl_dir;
  logic              pred_dir;
  logic              recover;
  logic              spec_shift;
  f2_t               f2_q;

  bpd_satcnt_tbl #(
    .DEPTH (LPHT_DEPTH),
    .W     (LCNTW),
    .INIT  (LCNT_INIT)
  ) u_loc_pht (
    .clock  (clock),
    .reset  (reset),
    .rd_idx (bpd_bht_lochist_f1_i),
    .rd_cnt (loc_cnt),
    .wr_en  (bpd_rt_we_i),
    .wr_idx (bpd_rt_lochist_i),
    .wr_inc (bpd_rt_brdir_i)
  );

  // Global table is read with the speculative GHR but trained with the retired snapshot.
  bpd_satcnt_tbl #(
    .DEPTH (GPHT_DEPTH),
    .W     (GCNTW),
    .INIT  (GCNT_INIT)
  ) u_glb_pht (
    .clock  (clock),
    .reset  (reset),
    .rd_idx (ghr),
    .rd_cnt (glb_cnt),
    .wr_en  (bpd_rt_we_i),
    .wr_idx (bpd_rt_ghist_i),
    .wr_inc (bpd_rt_brdir_i)
  );

  assign lo_dir     = loc_cnt[LCNTW-1];
  assign gl_dir     = glb_cnt[GCNTW-1];
  assign pred_dir   = pick_pred(bpd_pht_choice_f1_i, lo_dir, gl_dir);
  assign recover    = bpd_rt_we_i & bpd_rt_mispred_i;
  assign spec_shift = load_fetch_i & br_valid_f1_i;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      f2_q <= '0;
      ghr  <= '0;
    end else begin
      if (load_fetch_i) begin
        f2_q.pred   <= pred_dir;
        f2_q.lopred <= lo_dir;
        f2_q.glpred <= gl_dir;
        f2_q.valid  <= br_valid_f1_i;
        f2_q.ghist  <= ghr;
      end
      // A mispredict rebuilds history from the retired snapshot, discarding any speculation.
      if (recover) begin
        ghr <= {bpd_rt_ghist_i[GHISTW-2:0], bpd_rt_brdir_i};
      end else if (spec_shift) begin
        ghr <= {ghr[GHISTW-2:0], pred_dir};
      end
    end
  end

  assign bpd_pred_f2   = f2_q.pred;
  assign bpd_lopred_f2 = f2_q.lopred;
  assign bpd_glpred_f2 = f2_q.glpred;
  assign bpd_valid_f2  = f2_q.valid;
  assign bpd_ghist_f2  = f2_q.ghist;

  // Stage 1 XORs brdir with this; reporting the local guess steers choice toward the right side.
  assign bpd_ch_we_o    = bpd_rt_we_i & (bpd_rt_lopred_i != bpd_rt_glpred_i);
  assign bpd_ch_brdir_o = bpd_rt_lopred_i;

endmodule

// File: tb/tb_bpd2.sv
// Self-checking bench for bpd2: directed scenarios plus randomized traffic against a table model.
module tb_bpd2;
  import bpd2_pkg::*;

  logic              clock;
  logic              reset;
  logic              load_fetch_i;
  logic              br_valid_f1_i;
  logic              bpd_pht_choice_f1_i;
  logic [LHISTW-1:0] bpd_bht_lochist_f1_i;
  logic              bpd_rt_we_i;
  logic              bpd_rt_brdir_i;
  logic [LHISTW-1:0] bpd_rt_lochist_i;
  logic [GHISTW-1:0] bpd_rt_ghist_i;
  logic              bpd_rt_lopred_i;
  logic              bpd_rt_glpred_i;
  logic              bpd_rt_mispred_i;
  logic              bpd_pred_f2;
  logic              bpd_lopred_f2;
  logic              bpd_glpred_f2;
  logic              bpd_valid_f2;
  logic [GHISTW-1:0] bpd_ghist_f2;
  logic              bpd_ch_we_o;
  logic              bpd_ch_brdir_o;

  bpd2 dut (
    .clock                (clock),
    .reset                (reset),
    .load_fetch_i         (load_fetch_i),
    .br_valid_f1_i        (br_valid_f1_i),
    .bpd_pht_choice_f1_i  (bpd_pht_choice_f1_i),
    .bpd_bht_lochist_f1_i (bpd_bht_lochist_f1_i),
    .bpd_rt_we_i          (bpd_rt_we_i),
    .bpd_rt_brdir_i       (bpd_rt_brdir_i),
    .bpd_rt_lochist_i     (bpd_rt_lochist_i),
    .bpd_rt_ghist_i       (bpd_rt_ghist_i),
    .bpd_rt_lopred_i      (bpd_rt_lopred_i),
    .bpd_rt_glpred_i      (bpd_rt_glpred_i),
    .bpd_rt_mispred_i     (bpd_rt_mispred_i),
    .bpd_pred_f2          (bpd_pred_f2),
    .bpd_lopred_f2        (bpd_lopred_f2),
    .bpd_glpred_f2        (bpd_glpred_f2),
    .bpd_valid_f2         (bpd_valid_f2),
    .bpd_ghist_f2         (bpd_ghist_f2),
    .bpd_ch_we_o          (bpd_ch_we_o),
    .bpd_ch_brdir_o       (bpd_ch_brdir_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // Reference model: counters as plain integers, history as an integer mod 2^GHISTW.
  int lcnt [LPHT_DEPTH];
  int gcnt [GPHT_DEPTH];
  int m_ghr;
  int m_pred, m_lo, m_gl, m_valid, m_ghist;

  task automatic model_reset();
    for (int i = 0; i < LPHT_DEPTH; i++) lcnt[i] = 4;
    for (int i = 0; i < GPHT_DEPTH; i++) gcnt[i] = 2;
    m_ghr = 0; m_pred = 0; m_lo = 0; m_gl = 0; m_valid = 0; m_ghist = 0;
  endtask

  task automatic clear_inputs();
    load_fetch_i = 0; br_valid_f1_i = 0; bpd_pht_choice_f1_i = 0; bpd_bht_lochist_f1_i = '0;
    bpd_rt_we_i = 0; bpd_rt_brdir_i = 0; bpd_rt_lochist_i = '0; bpd_rt_ghist_i = '0;
    bpd_rt_lopred_i = 0; bpd_rt_glpred_i = 0; bpd_rt_mispred_i = 0;
  endtask

  // Advance the model by one clock using the inputs currently driven, then clock the DUT.
  task automatic cycle();
    int lo, gl, p, ng;
    lo = (lcnt[bpd_bht_lochist_f1_i] >= 4) ? 1 : 0;
    gl = (gcnt[m_ghr] >= 2) ? 1 : 0;
    p  = bpd_pht_choice_f1_i ? gl : lo;
    ng = m_ghr;
    if (load_fetch_i) begin
      m_lo = lo; m_gl = gl; m_pred = p; m_valid = br_valid_f1_i; m_ghist = m_ghr;
    end
    if (load_fetch_i && br_valid_f1_i) ng = (m_ghr * 2 + p) % GPHT_DEPTH;
    if (bpd_rt_we_i && bpd_rt_mispred_i) ng = (int'(bpd_rt_ghist_i) * 2 + bpd_rt_brdir_i) % GPHT_DEPTH;
    if (bpd_rt_we_i) begin
      if (bpd_rt_brdir_i) begin
        if (lcnt[bpd_rt_lochist_i] < 7) lcnt[bpd_rt_lochist_i]++;
        if (gcnt[bpd_rt_ghist_i] < 3) gcnt[bpd_rt_ghist_i]++;
      end else begin
        if (lcnt[bpd_rt_lochist_i] > 0) lcnt[bpd_rt_lochist_i]--;
        if (gcnt[bpd_rt_ghist_i] > 0) gcnt[bpd_rt_ghist_i]--;
      end
    end
    m_ghr = ng;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    model_reset();
    @(posedge clock);
    #1;
    reset = 0;
  endtask

  task automatic test_reset();
    logic [15:0] obs;
    reset = 1;
    load_fetch_i = 1; br_valid_f1_i = 1; bpd_rt_we_i = 1; bpd_rt_mispred_i = 1; bpd_rt_brdir_i = 1;
    model_reset();
    @(posedge clock);
    #1;
    obs = {bpd_pred_f2, bpd_lopred_f2, bpd_glpred_f2, bpd_valid_f2, bpd_ghist_f2};
    checks++;
    if (obs !== 16'h0) begin
      failures++;
      $display("FAIL reset_outputs: got %h expected 0000", obs);
    end
    clear_inputs();
    reset = 0;
  endtask

  task automatic test_first_pred();
    do_reset();
    load_fetch_i = 1; br_valid_f1_i = 1; bpd_pht_choice_f1_i = 0; bpd_bht_lochist_f1_i = '0;
    cycle();
    checks++;
    if ({bpd_pred_f2, bpd_lopred_f2, bpd_glpred_f2, bpd_valid_f2} !== 4'b1111) begin
      failures++;
      $display("FAIL first_pred_bits: got %b expected 1111",
               {bpd_pred_f2, bpd_lopred_f2, bpd_glpred_f2, bpd_valid_f2});
    end
    checks++;
    if (bpd_ghist_f2 !== 12'h000) begin
      failures++;
      $display("FAIL first_pred_ghist: got %h expected 000", bpd_ghist_f2);
    end
    br_valid_f1_i = 0;
    cycle();
    checks++;
    if (bpd_ghist_f2 !== 12'h001) begin
      failures++;
      $display("FAIL first_pred_ghr_shift: got %h expected 001", bpd_ghist_f2);
    end
    // f2 must hold while load is low even as f1 inputs change.
    load_fetch_i = 0; br_valid_f1_i = 1; bpd_bht_lochist_f1_i = 10'h155;
    cycle();
    checks++;
    if ({bpd_valid_f2, bpd_ghist_f2} !== {1'b0, 12'h001}) begin
      failures++;
      $display("FAIL hold_no_load: got %h expected 0001", {bpd_valid_f2, bpd_ghist_f2});
    end
  endtask

  task automatic test_local_sat();
    logic exp_lo [5];
    exp_lo = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    do_reset();
    bpd_rt_we_i = 1; bpd_rt_brdir_i = 0; bpd_rt_lochist_i = 10'h155; bpd_rt_ghist_i = 12'h555;
    load_fetch_i = 1; bpd_bht_lochist_f1_i = 10'h155;
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++;
      if (bpd_lopred_f2 !== exp_lo[i]) begin
        failures++;
        $display("FAIL local_dec_step%0d: got %b expected %b", i, bpd_lopred_f2, exp_lo[i]);
      end
    end
    bpd_rt_we_i = 0;
    cycle();
    checks++;
    if ({bpd_pred_f2, bpd_lopred_f2} !== 2'b00) begin
      failures++;
      $display("FAIL local_floor_pred: got %b expected 00", {bpd_pred_f2, bpd_lopred_f2});
    end
    // Nine increments from zero must stick at the top, not wrap back to a small value.
    bpd_rt_we_i = 1; bpd_rt_brdir_i = 1; load_fetch_i = 0;
    for (int i = 0; i < 9; i++) cycle();
    bpd_rt_we_i = 0; load_fetch_i = 1;
    cycle();
    checks++;
    if (bpd_lopred_f2 !== 1'b1) begin
      failures++;
      $display("FAIL local_ceiling: got %b expected 1", bpd_lopred_f2);
    end
  endtask

  task automatic test_global();
    do_reset();
    bpd_rt_we_i = 1; bpd_rt_brdir_i = 0; bpd_rt_ghist_i = 12'h000; bpd_rt_lochist_i = 10'h3FF;
    cycle();
    cycle();
    clear_inputs();
    load_fetch_i = 1; br_valid_f1_i = 1; bpd_pht_choice_f1_i = 1;
    cycle();
    checks++;
    if ({bpd_pred_f2, bpd_lopred_f2, bpd_glpred_f2} !== 3'b010) begin
      failures++;
      $display("FAIL global_choice1: got %b expected 010", {bpd_pred_f2, bpd_lopred_f2, bpd_glpred_f2});
    end
    bpd_pht_choice_f1_i = 0;
    cycle();
    checks++;
    if ({bpd_pred_f2, bpd_lopred_f2, bpd_ghist_f2} !== {2'b11, 12'h000}) begin
      failures++;
      $display("FAIL global_choice0: got %h expected 3000", {bpd_pred_f2, bpd_lopred_f2, bpd_ghist_f2});
    end
  endtask

  task automatic test_recovery_priority();
    do_reset();
    bpd_rt_we_i = 1; bpd_rt_mispred_i = 1; bpd_rt_ghist_i = 12'h078; bpd_rt_brdir_i = 0;
    cycle();
    clear_inputs();
    load_fetch_i = 1; br_valid_f1_i = 1;
    bpd_rt_we_i = 1; bpd_rt_mispred_i = 1; bpd_rt_ghist_i = 12'h800; bpd_rt_brdir_i = 1;
    cycle();
    checks++;
    if (bpd_ghist_f2 !== 12'h0F0) begin
      failures++;
      $display("FAIL recover_pre_ghr: got %h expected 0f0", bpd_ghist_f2);
    end
    clear_inputs();
    load_fetch_i = 1;
    cycle();
    checks++;
    if (bpd_ghist_f2 !== 12'h001) begin
      failures++;
      $display("FAIL recover_wins: got %h expected 001", bpd_ghist_f2);
    end
  endtask

  task automatic test_choice_outputs();
    logic [1:0] exp_tab [4];
    logic [2:0] in_tab [4];
    // {rt_we, lopred, glpred} -> {ch_we, ch_brdir}
    in_tab  = '{3'b110, 3'b111, 3'b101, 3'b010};
    exp_tab = '{2'b11,  2'b01,  2'b10,  2'b01};
    clear_inputs();
    for (int i = 0; i < 4; i++) begin
      {bpd_rt_we_i, bpd_rt_lopred_i, bpd_rt_glpred_i} = in_tab[i];
      #1;
      checks++;
      if ({bpd_ch_we_o, bpd_ch_brdir_o} !== exp_tab[i]) begin
        failures++;
        $display("FAIL choice_out%0d: got %b expected %b", i, {bpd_ch_we_o, bpd_ch_brdir_o}, exp_tab[i]);
      end
    end
    clear_inputs();
  endtask

  task automatic test_random();
    int bad = 0;
    logic [1:0] exp_ch;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      load_fetch_i         = ($urandom_range(0, 3) != 0);
      br_valid_f1_i        = $urandom_range(0, 1);
      bpd_pht_choice_f1_i  = $urandom_range(0, 1);
      bpd_bht_lochist_f1_i = LHISTW'($urandom_range(0, 7));
      bpd_rt_we_i          = $urandom_range(0, 1);
      bpd_rt_brdir_i       = $urandom_range(0, 1);
      bpd_rt_lochist_i     = LHISTW'($urandom_range(0, 7));
      bpd_rt_ghist_i       = GHISTW'($urandom_range(0, 15));
      bpd_rt_lopred_i      = $urandom_range(0, 1);
      bpd_rt_glpred_i      = $urandom_range(0, 1);
      bpd_rt_mispred_i     = ($urandom_range(0, 2) == 0);
      #1;
      exp_ch = {bpd_rt_we_i && (bpd_rt_lopred_i != bpd_rt_glpred_i), bpd_rt_lopred_i};
      checks++;
      if ({bpd_ch_we_o, bpd_ch_brdir_o} !== exp_ch) begin
        failures++;
        if (bad++ < 5) $display("FAIL rand_choice n=%0d: got %b expected %b", n, {bpd_ch_we_o, bpd_ch_brdir_o}, exp_ch);
      end
      cycle();
      checks++;
      if ({bpd_pred_f2, bpd_lopred_f2, bpd_glpred_f2, bpd_valid_f2, bpd_ghist_f2} !==
          {m_pred[0], m_lo[0], m_gl[0], m_valid[0], GHISTW'(m_ghist)}) begin
        failures++;
        if (bad++ < 5)
          $display("FAIL rand_f2 n=%0d: got %h expected %h", n,
                   {bpd_pred_f2, bpd_lopred_f2, bpd_glpred_f2, bpd_valid_f2, bpd_ghist_f2},
                   {m_pred[0], m_lo[0], m_gl[0], m_valid[0], GHISTW'(m_ghist)});
      end
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    logic [15:0] obs;
    do_reset();
    load_fetch_i = 1; br_valid_f1_i = 1; bpd_pht_choice_f1_i = 0;
    bpd_rt_we_i = 1; bpd_rt_brdir_i = 0; bpd_rt_lochist_i = 10'h155; bpd_rt_ghist_i = 12'h123;
    for (int i = 0; i < 3; i++) cycle();
    #2;
    reset = 1;
    model_reset();
    #1;
    obs = {bpd_pred_f2, bpd_lopred_f2, bpd_glpred_f2, bpd_valid_f2, bpd_ghist_f2};
    checks++;
    if (obs !== 16'h0) begin
      failures++;
      $display("FAIL async_reset: got %h expected 0000", obs);
    end
    @(posedge clock);
    #1;
    clear_inputs();
    reset = 0;
    load_fetch_i = 1; br_valid_f1_i = 1; bpd_bht_lochist_f1_i = 10'h155;
    cycle();
    checks++;
    if ({bpd_pred_f2, bpd_lopred_f2, bpd_ghist_f2} !== {2'b11, 12'h000}) begin
      failures++;
      $display("FAIL reset_restores: got %h expected 3000", {bpd_pred_f2, bpd_lopred_f2, bpd_ghist_f2});
    end
    br_valid_f1_i = 0;
    cycle();
    checks++;
    if (bpd_ghist_f2 !== 12'h001) begin
      failures++;
      $display("FAIL reset_ghr_restart: got %h expected 001", bpd_ghist_f2);
    end
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    #2;
    test_reset();
    test_first_pred();
    test_local_sat();
    test_global();
    test_recovery_priority();
    test_choice_outputs();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bpd2.md
BPD2 -- requirements
Module: bpd2

Interface
REQ-001 LHISTW, 10, local-history width; local PHT depth = 2^LHISTW.
REQ-002 GHISTW, 12, global-history width; global PHT depth = 2^GHISTW.
REQ-003 LCNTW, 3, local PHT counter width; reset value 3'b100.
REQ-004 GCNTW, 2, global PHT counter width; reset value 2'b10.
REQ-005 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-006 clock  in  1  rising-edge clock.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 load_fetch_i  in  1  fetch pipeline advance enable.
REQ-009 br_valid_f1_i  in  1  the f1 slot holds a conditional branch.
REQ-010 bpd_pht_choice_f1_i  in  1  choice counter MSB from stage 1; 1 selects global, 0 selects local.
REQ-011 bpd_bht_lochist_f1_i  in  LHISTW  local history from stage 1.
REQ-012 bpd_rt_we_i  in  1  retiring conditional branch, non-speculative update.
REQ-013 bpd_rt_brdir_i  in  1  resolved direction.
REQ-014 bpd_rt_lochist_i  in  LHISTW  local history used at prediction time.
REQ-015 bpd_rt_ghist_i  in  GHISTW  global history snapshot used at prediction time.
REQ-016 bpd_rt_lopred_i, bpd_rt_glpred_i  in  1 each  component predictions recorded at prediction time.
REQ-017 bpd_rt_mispred_i  in  1  retiring branch was mispredicted; qualified by bpd_rt_we_i.
REQ-018 bpd_pred_f2, bpd_lopred_f2, bpd_glpred_f2, bpd_valid_f2  out  1 each  registered final, local and global predictions, and slot valid.
REQ-019 bpd_ghist_f2  out  GHISTW  registered global-history snapshot used for this prediction.
REQ-020 bpd_ch_we_o, bpd_ch_brdir_o  out  1 each  combinational choice-update outputs to stage 1.

Function
REQ-021 Local PHT: 2^LHISTW x LCNTW saturating counters. Read index is bpd_bht_lochist_f1_i. Prediction is the counter MSB.
REQ-022 Global PHT: 2^GHISTW x GCNTW saturating counters. Read index is the speculative GHR. Prediction is the counter MSB.
REQ-023 On load_fetch_i, update the output registers: lopred_f2 and glpred_f2 take the PHT MSBs; pred_f2 = choice ? glpred : lopred; ghist_f2 = GHR; valid_f2 = br_valid_f1_i.
REQ-024 When load_fetch_i=0, all f2 outputs hold their values. Latency is one cycle from f1 to f2.
REQ-025 Speculative GHR update on load_fetch_i & br_valid_f1_i: GHR <= {GHR[GHISTW-2:0], predicted direction}, where the predicted direction is the same-cycle value written to pred_f2.
REQ-026 GHR recovery on bpd_rt_we_i & bpd_rt_mispred_i: GHR <= {bpd_rt_ghist_i[GHISTW-2:0], bpd_rt_brdir_i}.
REQ-027 When recovery and a speculative shift occur in the same cycle, recovery wins and the speculative shift is dropped.
REQ-028 On bpd_rt_we_i, local PHT[bpd_rt_lochist_i] increments if brdir=1 and decrements otherwise.
REQ-029 On bpd_rt_we_i, global PHT[bpd_rt_ghist_i] is updated by the same increment/decrement rule.
REQ-030 Counters saturate: no wrap at all-ones or at zero.
REQ-031 A same-cycle read and write to one entry SHALL return the pre-update value; the written value is visible from the next cycle.
REQ-032 bpd_ch_we_o = bpd_rt_we_i & (bpd_rt_lopred_i != bpd_rt_glpred_i).
REQ-033 bpd_ch_brdir_o = bpd_rt_lopred_i, so that stage 1's XOR with brdir moves the choice counter toward global when local was wrong.
REQ-034 PHT updates and GHR recovery are independent of load_fetch_i.

Reset
REQ-035 While reset=1: all f2 outputs = 0; GHR = 0; every local counter = 3'b100; every global counter = 2'b10.
REQ-036 An asserted reset mid-operation overrides any pending update in that cycle.

Structure
REQ-037 LHISTW, GHISTW, counter widths and counter init values belong in the shared branch-predictor package, alongside the stage-1 constants.
REQ-038 One sub-module, bpd_satcnt_tbl, is parameterised by depth, width and init, and provides async-read, sync-write saturating update. It is instantiated twice.

Verification
REQ-039 After reset, lochist_f1=0x000, choice=0, load=1, br_valid=1 -> next cycle pred_f2=1, lopred=1, glpred=1, valid=1, ghist_f2=0x000, GHR=0x001.
REQ-040 Retire 5x brdir=0 at lochist=0x155 -> counter 100->011->010->001->000->000. A later f1 read with lochist=0x155, choice=0 gives pred_f2=0.
REQ-041 Retire brdir=0 twice with ghist=0x000, then GHR=0 and choice=1 -> glpred=0 and pred=0. Choice=0 in the same setup gives pred=lopred=1.
REQ-042 Same cycle: speculative shift with GHR=0x0F0, plus mispredict retire with rt_ghist=0x800 and brdir=1 -> GHR=0x001 next cycle.
REQ-043 Retire with lopred=1, glpred=0, brdir=0 -> ch_we_o=1, ch_brdir_o=1. Retire with lopred=glpred=1 -> ch_we_o=0.
REQ-044 Assert reset for one cycle after 3 speculative shifts -> GHR=0, all f2 outputs=0, counter at 0x155 back to 3'b100.
